spi_flash_master: RTL and testbench



---
 rtl/spi_flash_master.sv | 148 ++++++++++++++
 tb/tb_spi_flash_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_master.sv
// Byte-wide SPI mode-0 master for the configuration flash: one write starts an
// 8-bit MSB-first full-duplex transfer; software polls busy then reads rd_data.
module spi_flash_master #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       wr,
  input  logic [7:0] wd,
  input  logic       cs_wr,
  input  logic       cs_wd,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  output logic       cs_n,
  input  logic       miso
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [1:0] state_r;
  logic [7:0] div_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] tx_sh_r;
  logic [7:0] rx_sh_r;
  logic [7:0] rd_data_r;
  logic       busy_r;
  logic       sck_r;
  logic       mosi_r;
  logic       cs_n_r;
  logic       phase_done_s;

  // End of the current SCK half-period.
  always_comb begin
    phase_done_s = (div_cnt_r == DIV_LAST);
  end

  // Transfer sequencer; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 3'd0;
      tx_sh_r   <= 8'h00;
      rx_sh_r   <= 8'h00;
      rd_data_r <= 8'h00;
      busy_r    <= 1'b0;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // CS only moves between bytes, so a strobe here may share the edge with wr.
          if (cs_wr) begin
            cs_n_r <= ~cs_wd;
          end
          if (wr) begin
            tx_sh_r   <= wd;
            mosi_r    <= wd[7];
            bit_cnt_r <= 3'd7;
            div_cnt_r <= 8'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_done_s) begin
            sck_r     <= 1'b1;
            rx_sh_r   <= {rx_sh_r[6:0], miso};
            div_cnt_r <= 8'd0;
            state_r   <= ST_HIGH;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_done_s) begin
            sck_r     <= 1'b0;
            div_cnt_r <= 8'd0;
            if (bit_cnt_r != 3'd0) begin
              bit_cnt_r <= bit_cnt_r - 3'd1;
              tx_sh_r   <= {tx_sh_r[6:0], 1'b0};
              mosi_r    <= tx_sh_r[6];
              state_r   <= ST_LOW;
            end else begin
              rd_data_r <= rx_sh_r;
              busy_r    <= 1'b0;
              mosi_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          div_cnt_r <= 8'd0;
          busy_r    <= 1'b0;
          sck_r     <= 1'b0;
          mosi_r    <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = rd_data_r;
  assign busy    = busy_r;
  assign sck     = sck_r;
  assign mosi    = mosi_r;
  assign cs_n    = cs_n_r;

  spi_flash_master_chk u_chk (
    .clk    (clk),
    .resetq (resetq),
    .busy   (busy_r),
    .sck    (sck_r),
    .mosi   (mosi_r),
    .cs_n   (cs_n_r)
  );

endmodule

// Protocol invariants of the flash master outputs.
module spi_flash_master_chk (
  input logic clk,
  input logic resetq,
  input logic busy,
  input logic sck,
  input logic mosi,
  input logic cs_n
);

  a_sck_only_busy: assert property (@(posedge clk) disable iff (!resetq)
    sck |-> busy);

  a_cs_stable_mid_byte: assert property (@(posedge clk) disable iff (!resetq)
    (busy && $past(busy)) |-> $stable(cs_n));

  a_mosi_hold_high: assert property (@(posedge clk) disable iff (!resetq)
    (sck && $past(sck)) |-> $stable(mosi));

endmodule

// File: tb/tb_spi_flash_master.sv
// Scoreboard bench for spi_flash_master: DIV=2 loopback instance and DIV=1
// instance talking to a small flash model that always returns 3C.
module tb_spi_flash_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetq;
  logic       wr0, cs_wr0, cs_wd0, busy0, sck0, mosi0, cs_n0, miso0;
  logic       wr1, cs_wr1, cs_wd1, busy1, sck1, mosi1, cs_n1, miso1;
  logic [7:0] wd0, rd0, wd1, rd1;

  spi_flash_master #(.DIV(2)) u_dut_div2 (
    .clk(clk), .resetq(resetq), .wr(wr0), .wd(wd0), .cs_wr(cs_wr0), .cs_wd(cs_wd0),
    .rd_data(rd0), .busy(busy0), .sck(sck0), .mosi(mosi0), .cs_n(cs_n0), .miso(miso0)
  );

  spi_flash_master #(.DIV(1)) u_dut_div1 (
    .clk(clk), .resetq(resetq), .wr(wr1), .wd(wd1), .cs_wr(cs_wr1), .cs_wd(cs_wd1),
    .rd_data(rd1), .busy(busy1), .sck(sck1), .mosi(mosi1), .cs_n(cs_n1), .miso(miso1)
  );

  assign miso0 = mosi0;

  // Flash model: presents 3C MSB first, advancing after each sampling edge.
  logic [7:0] fl_byte;
  logic [2:0] fl_cnt;
  logic [2:0] fl_idx;
  logic       fl_prev;
  assign fl_byte = 8'h3C;
  assign fl_idx  = 3'd7 - fl_cnt;
  assign miso1   = fl_byte[fl_idx];
  always @(posedge clk) begin
    fl_prev <= sck1;
    if (!busy1) fl_cnt <= 3'd0;
    else if (sck1 && !fl_prev) fl_cnt <= fl_cnt + 3'd1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_rd_q0[$];
  logic [7:0] exp_rd_q1[$];
  logic       exp_bit_q0[$];
  logic       exp_bit_q1[$];

  logic prev_busy[2];
  logic prev_sck[2];
  logic prev_mosi[2];
  int   busy_len[2];
  int   hi_len[2];
  int   lo_len[2];
  int   rises[2];

  task automatic mon(input int d);
    logic b, s, m, eb, ok;
    logic [7:0] rd, er;
    int dv;
    b  = (d == 0) ? busy0 : busy1;
    s  = (d == 0) ? sck0  : sck1;
    m  = (d == 0) ? mosi0 : mosi1;
    rd = (d == 0) ? rd0   : rd1;
    dv = (d == 0) ? 2 : 1;
    if (!resetq) begin
      prev_busy[d] = 1'b0; prev_sck[d] = 1'b0; prev_mosi[d] = 1'b0;
      busy_len[d] = 0; hi_len[d] = 0; lo_len[d] = 0; rises[d] = 0;
    end else begin
      if (b && !prev_busy[d]) begin
        busy_len[d] = 0; rises[d] = 0; lo_len[d] = 0; hi_len[d] = 0;
      end
      if (m !== prev_mosi[d]) begin
        ok = (prev_sck[d] && !s) || (b && !prev_busy[d]);
        check_val($sformatf("mosi_edge%0d", d), {31'd0, ok}, 32'd1);
      end
      if (s && !prev_sck[d]) begin
        check_val($sformatf("sck_low_width%0d", d), lo_len[d], dv);
        if (d == 0 && exp_bit_q0.size() > 0) begin
          eb = exp_bit_q0.pop_front();
          check_val($sformatf("mosi_bit%0d", d), {31'd0, m}, {31'd0, eb});
        end else if (d == 1 && exp_bit_q1.size() > 0) begin
          eb = exp_bit_q1.pop_front();
          check_val($sformatf("mosi_bit%0d", d), {31'd0, m}, {31'd0, eb});
        end else begin
          check_val($sformatf("unexpected_sck%0d", d), 32'(rises[d] + 100), 32'd0);
        end
        rises[d]++;
        lo_len[d] = 0;
      end
      if (!s && prev_sck[d]) begin
        check_val($sformatf("sck_high_width%0d", d), hi_len[d], dv);
        hi_len[d] = 0;
      end
      if (s) hi_len[d]++;
      else if (b) lo_len[d]++;
      if (b) busy_len[d]++;
      if (!b && prev_busy[d]) begin
        check_val($sformatf("busy_len%0d", d), busy_len[d], 16 * dv);
        check_val($sformatf("sck_pulses%0d", d), rises[d], 8);
        if (d == 0 && exp_rd_q0.size() > 0) begin
          er = exp_rd_q0.pop_front();
          check_val("rd_data0", rd, er);
        end else if (d == 1 && exp_rd_q1.size() > 0) begin
          er = exp_rd_q1.pop_front();
          check_val("rd_data1", rd, er);
        end else begin
          check_val($sformatf("unexpected_done%0d", d), 32'(d + 1), 32'd0);
        end
      end
      prev_busy[d] = b; prev_sck[d] = s; prev_mosi[d] = m;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input logic [7:0] b, input logic with_cs, input logic [7:0] exp);
    if (d == 0) begin
      wr0 = 1'b1; wd0 = b; cs_wr0 = with_cs; cs_wd0 = 1'b1;
      exp_rd_q0.push_back(exp);
      for (int i = 7; i >= 0; i--) exp_bit_q0.push_back(b[i]);
    end else begin
      wr1 = 1'b1; wd1 = b; cs_wr1 = with_cs; cs_wd1 = 1'b1;
      exp_rd_q1.push_back(exp);
      for (int i = 7; i >= 0; i--) exp_bit_q1.push_back(b[i]);
    end
    tick();
    wr0 = 1'b0; cs_wr0 = 1'b0; wr1 = 1'b0; cs_wr1 = 1'b0;
    check_val($sformatf("busy_rise%0d", d), (d == 0) ? busy0 : busy1, 1'b1);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    while (((d == 0) ? busy0 : busy1) && n < budget) begin
      tick();
      n++;
    end
    check_val($sformatf("idle_timeout%0d", d), (d == 0) ? busy0 : busy1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    logic ps;
    resetq = 1'b0;
    wr0 = 1'b0; wd0 = 8'h00; cs_wr0 = 1'b0; cs_wd0 = 1'b0;
    wr1 = 1'b0; wd1 = 8'h00; cs_wr1 = 1'b0; cs_wd1 = 1'b0;
    tick();
    tick();
    resetq = 1'b1;

    // Reset values held through idle.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("idle0", {cs_n0, sck0, busy0, mosi0, rd0}, {1'b1, 3'b000, 8'h00});
      check_val("idle1", {cs_n1, sck1, busy1, mosi1, rd1}, {1'b1, 3'b000, 8'h00});
    end

    // Loopback A5 at DIV=2.
    cs_wr0 = 1'b1; cs_wd0 = 1'b1;
    tick();
    cs_wr0 = 1'b0;
    check_val("cs_assert0", cs_n0, 1'b0);
    start(0, 8'hA5, 1'b0, 8'hA5);
    wait_idle(0, 100);
    check_val("loop_a5", rd0, 8'hA5);
    tick();

    // Flash returns 3C at DIV=1; CS and wr on the same edge.
    start(1, 8'h9F, 1'b1, 8'h3C);
    check_val("cs_with_wr1", cs_n1, 1'b0);
    wait_idle(1, 50);
    check_val("flash_3c", rd1, 8'h3C);
    tick();

    // CS strobe mid-byte is ignored; the same strobe afterwards takes effect.
    start(0, 8'hC3, 1'b0, 8'hC3);
    repeat (5) tick();
    cs_wr0 = 1'b1; cs_wd0 = 1'b0;
    tick();
    cs_wr0 = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      check_val("cs_hold0", cs_n0, 1'b0);
      tick();
      n++;
    end
    check_val("cs_done_busy0", busy0, 1'b0);
    check_val("cs_after_byte0", cs_n0, 1'b0);
    cs_wr0 = 1'b1; cs_wd0 = 1'b0;
    tick();
    cs_wr0 = 1'b0;
    check_val("cs_release0", cs_n0, 1'b1);

    // Write while busy is dropped: 00 goes out untouched, no second byte.
    start(0, 8'h00, 1'b0, 8'h00);
    repeat (4) tick();
    wr0 = 1'b1; wd0 = 8'hFF;
    tick();
    wr0 = 1'b0;
    wait_idle(0, 100);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("no_second0", busy0, 1'b0);
    end

    // Reset after the third SCK rise aborts the byte.
    start(0, 8'h96, 1'b1, 8'h96);
    r = 0; n = 0; ps = sck0;
    while (r < 3 && n < 100) begin
      tick();
      n++;
      if (sck0 && !ps) r++;
      ps = sck0;
    end
    check_val("rise3", r, 3);
    resetq = 1'b0;
    exp_rd_q0.delete();
    exp_bit_q0.delete();
    tick();
    check_val("abort0", {sck0, cs_n0, busy0, mosi0, rd0}, {1'b0, 1'b1, 2'b00, 8'h00});
    resetq = 1'b1;
    tick();
    tick();
    start(0, 8'h5A, 1'b1, 8'h5A);
    wait_idle(0, 100);
    check_val("after_reset_5a", rd0, 8'h5A);
    tick();

    check_val("rdq0_left", exp_rd_q0.size(), 0);
    check_val("rdq1_left", exp_rd_q1.size(), 0);
    check_val("bitq0_left", exp_bit_q0.size(), 0);
    check_val("bitq1_left", exp_bit_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
